// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber matrix-sampling path.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int COEFF_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SPLIT = 3'd3,
    ST_DRAIN = 3'd4
  } parse_state_t;

endpackage

// File: rtl/parse_byte_buf.sv
// Byte buffer for the rejection sampler: appends a squeeze word behind up to two
// residual bytes and pops the oldest three. The oldest byte sits in bits [7:0].
module parse_byte_buf #(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_dat_i,
  input  logic              pop3_i,
  output logic [3:0]        cnt_o,
  output logic [23:0]       peek_o
);

  localparam int BUF_W = WORD_W + 16;

  logic [BUF_W-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;

  // Bytes above cnt_q are always zero, so a push can simply OR in the shifted word.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (push_i) begin
      data_d = data_q | ({16'b0, push_dat_i} << {cnt_q, 3'b000});
      cnt_d  = cnt_q + 4'(WORD_W / 8);
    end else if (pop3_i) begin
      data_d = data_q >> 24;
      cnt_d  = cnt_q - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign peek_o = data_q[23:0];

endmodule

// File: rtl/kyber_parse.sv
// Kyber Parse/SampleNTT rejection sampler: pulls SHAKE128 squeeze words, splits each
// 3-byte group into two 12-bit candidates and streams those below Q as coefficients.
module kyber_parse
  import kyber_pkg::*;
#(
  parameter int N_COEFF = KYBER_N,
  parameter int Q       = KYBER_Q,
  parameter int WORD_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       gimme,
  output logic [COEFF_W-1:0]         coeff_out,
  output logic [$clog2(N_COEFF)-1:0] coeff_idx,
  output logic                       coeff_valid,
  input  logic                       coeff_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       proto_err
);

  localparam int CNT_W = $clog2(N_COEFF) + 1;
  localparam int IDX_W = $clog2(N_COEFF);

  parse_state_t       state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic               half_q, half_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d, cand;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               buf_clr, buf_push, buf_pop;
  logic [3:0]         buf_cnt;
  logic [23:0]        buf_peek;
  logic               hs, out_free;

  parse_byte_buf #(.WORD_W(WORD_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (buf_clr),
    .push_i     (buf_push),
    .push_dat_i (in_data),
    .pop3_i     (buf_pop),
    .cnt_o      (buf_cnt),
    .peek_o     (buf_peek)
  );

  // half_q selects d2 of the current triple; the triple is popped once d2 is evaluated.
  assign cand      = half_q ? buf_peek[23:12] : buf_peek[11:0];
  assign hs        = vld_q & coeff_ready;
  assign out_free  = ~vld_q | coeff_ready;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    half_d   = half_q;
    coeff_d  = coeff_q;
    idx_d    = idx_q;
    vld_d    = vld_q & ~hs;
    busy_d   = busy_q;
    done_d   = 1'b0;
    perr_d   = perr_q;
    buf_clr  = 1'b0;
    buf_push = 1'b0;
    buf_pop  = 1'b0;
    if (start) begin
      state_d = ST_REQ;
      busy_d  = 1'b1;
      count_d = '0;
      half_d  = 1'b0;
      coeff_d = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
      perr_d  = 1'b0;
      buf_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) perr_d = 1'b1;
        ST_REQ: begin
          buf_push = in_valid;
          state_d  = in_valid ? ST_SPLIT : ST_WAIT;
        end
        ST_WAIT: begin
          buf_push = in_valid;
          state_d  = in_valid ? ST_SPLIT : ST_REQ;
        end
        ST_SPLIT: begin
          if (in_valid) perr_d = 1'b1;
          if (!half_q && buf_cnt < 4'd3) begin
            state_d = ST_REQ;
          end else if (out_free) begin
            half_d  = ~half_q;
            buf_pop = half_q;
            if (cand < COEFF_W'(Q)) begin
              coeff_d = cand;
              idx_d   = count_q[IDX_W-1:0];
              vld_d   = 1'b1;
              count_d = count_inc;
              if (count_inc == CNT_W'(N_COEFF)) state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (in_valid) perr_d = 1'b1;
          if (hs) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            buf_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      half_q  <= 1'b0;
      coeff_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      half_q  <= half_d;
      coeff_q <= coeff_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign gimme       = (state_q == ST_REQ);
  assign coeff_out   = coeff_q;
  assign coeff_idx   = idx_q;
  assign coeff_valid = vld_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_kyber_parse.sv
// Randomized scoreboard bench for kyber_parse with a byte-stream reference model.
module tb_kyber_parse;

  localparam int Q = 3329;
  localparam int N = 256;
  localparam logic [63:0] W_T1  = 64'hFFFF_FFFF_FF03_0201;
  localparam logic [63:0] W_T2A = 64'h0005_FFFF_FFD0_1D00;
  localparam logic [63:0] W_T2B = 64'h0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        gimme;
  logic [11:0] coeff_out;
  logic [7:0]  coeff_idx;
  logic        coeff_valid;
  logic        coeff_ready = 1'b0;
  logic        busy, done, proto_err;

  kyber_parse dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .gimme       (gimme),
    .coeff_out   (coeff_out),
    .coeff_idx   (coeff_idx),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .busy        (busy),
    .done        (done),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int idx;
  } exp_t;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [7:0]  mbytes[$];
  int          mcount = 0;
  logic [63:0] src_q[$];
  logic [63:0] sent_q[$];
  int          log_val[$];
  int          log_idx[$];
  int          log_cyc[$];
  bit          feed_en = 0, auto_gen = 0, pend = 0, inj = 0;
  bit          rdy_rand = 0, rdy_fixed = 1;
  int          lat_mode = 0;
  logic [63:0] inj_word = '0;
  int          cyc = 0, done_cnt = 0;
  bit          prev_stall = 0;
  int          prev_out = 0, prev_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the polynomial is the first N accepted values of the concatenated byte stream.
  task automatic model_push(input logic [63:0] w);
    int b0, b1, b2, d1, d2;
    exp_t e;
    for (int k = 0; k < 8; k++) mbytes.push_back(w[8*k +: 8]);
    while (mbytes.size() >= 3 && mcount < N) begin
      b0 = int'(mbytes.pop_front());
      b1 = int'(mbytes.pop_front());
      b2 = int'(mbytes.pop_front());
      d1 = b0 + 256 * (b1 % 16);
      d2 = b1 / 16 + 16 * b2;
      if (d1 < Q) begin
        e.val = d1; e.idx = mcount; exp_q.push_back(e); mcount++;
      end
      if (mcount < N && d2 < Q) begin
        e.val = d2; e.idx = mcount; exp_q.push_back(e); mcount++;
      end
    end
  endtask

  task automatic present();
    logic [63:0] w;
    if (src_q.size() > 0) w = src_q.pop_front();
    else if (auto_gen) w = {$urandom, $urandom};
    else return;
    in_valid = 1'b1;
    in_data  = w;
    sent_q.push_back(w);
    model_push(w);
  endtask

  // Keccak FIFO stand-in: answers gimme immediately, one cycle late, or not at all.
  initial begin
    int mode;
    forever begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      if (inj) begin
        in_valid = 1'b1; in_data = inj_word; inj = 0;
      end else if (!feed_en) begin
        pend = 0;
      end else if (pend) begin
        pend = 0; present();
      end else if (gimme) begin
        mode = (lat_mode == 2) ? int'($urandom_range(0, 2)) : lat_mode;
        if (mode == 0) present();
        else if (mode == 1) pend = 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      coeff_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'(rdy_fixed);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      cyc++;
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", int'(coeff_valid), 1);
        chk("stall_data", int'(coeff_out), prev_out);
        chk("stall_idx", int'(coeff_idx), prev_idx);
      end
      if (coeff_valid && coeff_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_coeff: got %0d idx %0d, expected no coefficient",
                   coeff_out, coeff_idx);
        end else begin
          e = exp_q.pop_front();
          chk("coeff_val", int'(coeff_out), e.val);
          chk("coeff_idx", int'(coeff_idx), e.idx);
        end
        log_val.push_back(int'(coeff_out));
        log_idx.push_back(int'(coeff_idx));
        log_cyc.push_back(cyc);
      end
      prev_stall = coeff_valid && !coeff_ready && !start;
      prev_out   = int'(coeff_out);
      prev_idx   = int'(coeff_idx);
    end
  end

  // Call aligned just after a rising edge; start is seen at the following edge.
  task automatic do_start();
    feed_en = 0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mbytes.delete(); mcount = 0; exp_q.delete(); sent_q.delete();
    log_val.delete(); log_idx.delete(); log_cyc.delete();
    feed_en = 1;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > base) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected one", name, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int base, mism;
    int saved[$];
    logic [63:0] words4[$];
    bit found;

    repeat (3) @(negedge clk);
    chk("rst_gimme", int'(gimme), 0);
    chk("rst_valid", int'(coeff_valid), 0);
    chk("rst_out", int'(coeff_out), 0);
    chk("rst_idx", int'(coeff_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_perr", int'(proto_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic split, zero-latency FIFO.
    lat_mode = 0;
    src_q.push_back(W_T1);
    do_start();
    repeat (20) @(posedge clk); #1;
    chk("t1_count", log_val.size(), 2);
    if (log_val.size() >= 2) begin
      chk("t1_val0", log_val[0], 513);
      chk("t1_idx0", log_idx[0], 0);
      chk("t1_val1", log_val[1], 48);
      chk("t1_idx1", log_idx[1], 1);
      chk("t1_back_to_back", log_cyc[1] - log_cyc[0], 1);
    end

    // Bound values and an all-reject triple, with residual carried into the next word.
    src_q.push_back(W_T2A);
    src_q.push_back(W_T2B);
    do_start();
    repeat (40) @(posedge clk); #1;
    chk("t2_count", log_val.size(), 7);
    if (log_val.size() >= 7) begin
      chk("t2_qm1_val", log_val[0], 3328);
      chk("t2_qm1_idx", log_idx[0], 0);
      chk("t2_carry_val", log_val[1], 5);
      chk("t2_carry_idx", log_idx[1], 1);
      chk("t2_last_idx", log_idx[6], 6);
    end

    // Empty FIFO: REQ/WAIT retry loop, then a late word captured once.
    lat_mode = 1;
    do_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_gimme", int'(gimme), int'(i % 2 == 0));
    end
    @(posedge clk); #1;
    src_q.push_back(W_T1);
    repeat (30) @(posedge clk); #1;
    chk("t3_count", log_val.size(), 2);
    if (log_val.size() >= 2) begin
      chk("t3_val0", log_val[0], 513);
      chk("t3_val1", log_val[1], 48);
    end

    // Full random polynomial.
    lat_mode = 2; auto_gen = 1; rdy_fixed = 1;
    base = done_cnt;
    do_start();
    @(negedge clk);
    chk("t4_busy_run", int'(busy), 1);
    wait_done(base, 5000, "t4");
    repeat (5) @(posedge clk); #1;
    chk("t4_done_pulses", done_cnt - base, 1);
    chk("t4_coeffs", log_val.size(), N);
    chk("t4_exp_left", exp_q.size(), 0);
    chk("t4_busy_end", int'(busy), 0);
    if (log_idx.size() == N) chk("t4_last_idx", log_idx[N-1], N - 1);
    saved  = log_val;
    words4 = sent_q;

    // Same stream with random backpressure.
    src_q = words4;
    rdy_rand = 1;
    base = done_cnt;
    do_start();
    wait_done(base, 8000, "t5");
    repeat (5) @(posedge clk); #1;
    rdy_rand = 0;
    chk("t5_done_pulses", done_cnt - base, 1);
    chk("t5_coeffs", log_val.size(), N);
    mism = 0;
    for (int i = 0; i < N && i < log_val.size() && i < saved.size(); i++)
      if (log_val[i] != saved[i]) mism++;
    chk("t5_same_values", mism, 0);

    // Stray word while idle.
    inj_word = 64'h1234; inj = 1;
    repeat (2) @(negedge clk);
    chk("idle_perr", int'(proto_err), 1);
    @(posedge clk); #1;

    // Abort mid-polynomial with a protocol error pending.
    lat_mode = 0;
    base = done_cnt;
    do_start();
    @(negedge clk);
    chk("t6_perr_cleared", int'(proto_err), 0);
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk); #1;
      if (log_val.size() >= 50 && busy && !gimme) begin
        inj_word = {$urandom, $urandom}; inj = 1; found = 1;
      end
    end
    chk("t6_inject_reached", int'(found), 1);
    repeat (2) @(negedge clk);
    chk("t6_perr_set", int'(proto_err), 1);
    @(posedge clk); #1;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (coeff_valid && coeff_idx == 8'd100) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("t6_idx100_reached", int'(found), 1);
    chk("t6_perr_hold", int'(proto_err), 1);
    do_start();
    @(negedge clk);
    chk("t6_abort_valid", int'(coeff_valid), 0);
    chk("t6_abort_perr", int'(proto_err), 0);
    chk("t6_abort_busy", int'(busy), 1);
    chk("t6_abort_no_done", done_cnt - base, 0);
    wait_done(base, 5000, "t6");
    repeat (5) @(posedge clk); #1;
    chk("t6_done_pulses", done_cnt - base, 1);
    chk("t6_coeffs", log_val.size(), N);
    if (log_idx.size() > 0) chk("t6_restart_idx", log_idx[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
